// File: rtl/moore_table_fsm.sv
// moore_table_fsm: run-time programmable, table-driven Moore state machine.
// The next-state table (rows = current state, columns = input value) and the
// per-state output table are register arrays written through a config port.
// Optional dwell counter enabled by defining MOORE_TABLE_FSM_DWELL_EN;
// without it the dwell port is tied to zero.
module moore_table_fsm #(
  parameter int IN_W        = 2,
  parameter int ST_W        = 2,
  parameter int OUT_W       = 1,
  parameter int START_STATE = 0,
  parameter int DW_W        = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             run,
  input  logic             clr,
  input  logic [IN_W-1:0]  in_x,
  input  logic             cfg_we,
  input  logic [ST_W-1:0]  cfg_state,
  input  logic [IN_W-1:0]  cfg_in,
  input  logic [ST_W-1:0]  cfg_next,
  input  logic             cfg_out_we,
  input  logic [OUT_W-1:0] cfg_out,
  output logic [ST_W-1:0]  state,
  output logic [OUT_W-1:0] out_z,
  output logic             changed,
  output logic [DW_W-1:0]  dwell
);

  localparam int NS = 2 ** ST_W;
  localparam int NI = 2 ** IN_W;
  localparam logic [ST_W-1:0] START_S = ST_W'(START_STATE);

  logic [ST_W-1:0]  next_q [NS][NI];
  logic [OUT_W-1:0] out_q  [NS];

  logic [ST_W-1:0]  state_q, state_d;
  logic             changed_q, changed_d;

  // Table storage: reset to self-loops / zero outputs, then written by config.
  // A write lands at the edge, so a transition on the same edge reads the old entry.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int s = 0; s < NS; s++) begin
        out_q[s] <= '0;
        for (int i = 0; i < NI; i++) begin
          next_q[s][i] <= ST_W'(s);
        end
      end
    end else begin
      if (cfg_we) begin
        next_q[cfg_state][cfg_in] <= cfg_next;
      end
      if (cfg_out_we) begin
        out_q[cfg_state] <= cfg_out;
      end
    end
  end

  // Next-state selection: restart beats run, otherwise hold.
  always_comb begin
    state_d   = state_q;
    changed_d = 1'b0;
    if (clr) begin
      state_d = START_S;
    end else if (run) begin
      state_d = next_q[state_q][in_x];
    end
    changed_d = (state_d != state_q);
  end

  // State and change-pulse registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= START_S;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= changed_d;
    end
  end

  assign state   = state_q;
  assign changed = changed_q;
  // Moore output depends only on the registered state.
  assign out_z   = out_q[state_q];

`ifdef MOORE_TABLE_FSM_DWELL_EN
  logic [DW_W-1:0] dwell_q, dwell_d;

  // Dwell: clear on any state change or restart, count run edges, saturate.
  always_comb begin
    dwell_d = dwell_q;
    if (clr || (state_d != state_q)) begin
      dwell_d = '0;
    end else if (run && (dwell_q != '1)) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign dwell = dwell_q;
`else
  assign dwell = '0;
`endif

endmodule
